// File: rtl/mem_word_byte_bridge.sv
// Serializes 32-bit word reads/writes into little-endian byte beats on a
// single-port byte memory, gathering read bytes and aborting on a stalled beat.
module mem_word_byte_bridge #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        up_read,
   input  logic        up_write,
   input  logic [31:0] up_addr,
   input  logic [31:0] up_wdata,
   input  logic [3:0]  up_wmask,
   output logic [31:0] up_rdata,
   output logic        up_resp,
   output logic        up_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_resp
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      idx_reg;
   logic            op_read_reg;
   logic [31:0]     addr_reg;
   logic [31:0]     wdata_reg;
   logic [3:0]      wmask_reg;
   logic [CW-1:0]   wait_cnt_reg;
   logic [31:0]     rdata_reg;
   logic [31:0]     rdata_next;

   logic accept;
   logic active;
   logic timed_out;
   logic last_beat;

   assign accept    = (state_reg == IDLE) && (up_read || up_write);
   assign active    = op_read_reg || wmask_reg[idx_reg];
   assign timed_out = (TIMEOUT > 0) && (wait_cnt_reg == WAIT_MAX);
   assign last_beat = (idx_reg == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: if (up_read || up_write) state_next = REQ;
         REQ: begin
            if (active) begin
               if (mem_resp)       state_next = GAP;
               else if (timed_out) state_next = ERR;
            end else if (last_beat) begin
               state_next = DONE;
            end
         end
         GAP:     state_next = last_beat ? DONE : REQ;
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      up_resp   = 1'b0;
      up_err    = 1'b0;
      unique case (state_reg)
         REQ: begin
            mem_read  = op_read_reg;
            mem_write = !op_read_reg && wmask_reg[idx_reg];
            if (active) begin
               mem_addr  = addr_reg + {30'd0, idx_reg};
               mem_wdata = wdata_reg[{idx_reg, 3'b000} +: 8];
            end
         end
         DONE:    up_resp = 1'b1;
         ERR:     up_err  = 1'b1;
         default: ;
      endcase
   end

   // Request latches and beat index; both strobes high is treated as a read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_read_reg <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wmask_reg   <= '0;
         idx_reg     <= '0;
      end else if (accept) begin
         op_read_reg <= up_read;
         addr_reg    <= up_addr;
         wdata_reg   <= up_wdata;
         wmask_reg   <= up_wmask;
         idx_reg     <= '0;
      end else if (!last_beat &&
                   (((state_reg == REQ) && !active) || (state_reg == GAP))) begin
         idx_reg <= idx_reg + 2'd1;
      end
   end

   // Counts unanswered cycles of the current active beat; zero everywhere else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
      end else if ((state_reg == REQ) && active && !mem_resp && !timed_out) begin
         wait_cnt_reg <= wait_cnt_reg + CW'(1);
      end else begin
         wait_cnt_reg <= '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rdata_next[8*gi +: 8] =
            (accept && up_read) ? 8'h00 :
            ((state_reg == REQ) && op_read_reg && mem_resp && (idx_reg == 2'(gi))) ?
               mem_rdata : rdata_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_reg <= '0;
      end else begin
         rdata_reg <= rdata_next;
      end
   end

   assign up_rdata = rdata_reg;

endmodule
